// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants and the PIPE_STAGES legality check for
// the and_gate block.
//   PIPE_STAGES_MAX : deepest registered path supported
//   STATS_CNT_W     : width of the optional hit counter (AND_GATE_STATS_EN)
package and_gate_pkg;

  localparam int PIPE_STAGES_MAX = 4;
  localparam int STATS_CNT_W     = 16;

  // Legal registered-path depth is 1..PIPE_STAGES_MAX.
  function automatic bit pipe_stages_legal(input int n);
    return (n >= 1) && (n <= PIPE_STAGES_MAX);
  endfunction

endpackage

// File: rtl/and_gate_reg_stage.sv
// and_gate_reg_stage: one stage of the registered path. A single DW-bit
// flop that captures every rising edge and clears asynchronously.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   d     : stage input  ({valid, data})
//   q     : stage output ({valid, data})
module and_gate_reg_stage #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage_d, stage_q;

  always_comb stage_d = d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q;

endmodule

// File: rtl/and_gate.sv
// and_gate: bitwise 2-input AND. Y and all_ones are purely combinational
// (usable with no clock and while in reset); y_q/out_valid are a
// PIPE_STAGES-deep registered copy of {A & B, in_valid}.
//   clk       : rising-edge clock, registered path only
//   rst_n     : asynchronous active-low reset of the registered path
//   A, B      : WIDTH-bit operands
//   in_valid  : qualifies A/B for the registered path (no backpressure)
//   Y         : A & B
//   all_ones  : &Y
//   y_q       : A & B delayed PIPE_STAGES cycles
//   out_valid : in_valid delayed PIPE_STAGES cycles
//   hit_cnt   : only when AND_GATE_STATS_EN is defined; saturating count of
//               edges with in_valid && all_ones
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones
`ifdef AND_GATE_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] hit_cnt
`endif
);

  if (!pipe_stages_legal(PIPE_STAGES)) begin : g_bad_cfg
    $error("and_gate: PIPE_STAGES must be 1..%0d", PIPE_STAGES_MAX);
  end

  assign Y        = A & B;
  assign all_ones = &Y;

  // pipe[0] is the live input; pipe[i+1] is the output of stage i.
  // Data is captured regardless of in_valid so y_q always tracks A & B.
  logic [PIPE_STAGES:0][WIDTH:0] pipe;

  assign pipe[0] = {in_valid, Y};

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    and_gate_reg_stage #(.DW(WIDTH + 1)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pipe[g]),
      .q     (pipe[g+1])
    );
  end

  assign {out_valid, y_q} = pipe[PIPE_STAGES];

`ifdef AND_GATE_STATS_EN
  logic [STATS_CNT_W-1:0] hit_cnt_d, hit_cnt_q;

  // Saturate rather than wrap so a full counter still reads as "many".
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (in_valid && all_ones && (hit_cnt_q != {STATS_CNT_W{1'b1}}))
      hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;

  // WIDTH=1, PIPE_STAGES=2
  logic [0:0] a1 = '0, b1 = '0, y1, yq1;
  logic       v1 = 1'b0, ov1, ao1;
  // WIDTH=8, PIPE_STAGES=2
  logic [7:0] a8 = '0, b8 = '0, y8, yq8;
  logic       v8 = 1'b0, ov8, ao8;
  // WIDTH=4, PIPE_STAGES=4
  logic [3:0] a4 = '0, b4 = '0, y4, yq4;
  logic       v4 = 1'b0, ov4, ao4;
`ifdef AND_GATE_STATS_EN
  logic [15:0] hc1, hc8, hc4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  and_gate #(.WIDTH(1), .PIPE_STAGES(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(v1),
    .Y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(ao1)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hc1)
`endif
  );

  and_gate #(.WIDTH(8), .PIPE_STAGES(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(v8),
    .Y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(ao8)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hc8)
`endif
  );

  and_gate #(.WIDTH(4), .PIPE_STAGES(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(v4),
    .Y(y4), .y_q(yq4), .out_valid(ov4), .all_ones(ao4)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hc4)
`endif
  );

  task test_reset;
    #1;
    n_tests++;
    if ({yq1, ov1} !== 2'b0) begin
      n_fail++; $display("FAIL reset_w1 got yq=%b ov=%b want 0 0", yq1, ov1);
    end
    n_tests++;
    if ({yq8, ov8} !== 9'b0) begin
      n_fail++; $display("FAIL reset_w8 got yq=%h ov=%b want 00 0", yq8, ov8);
    end
    n_tests++;
    if ({yq4, ov4} !== 5'b0) begin
      n_fail++; $display("FAIL reset_p4 got yq=%h ov=%b want 0 0", yq4, ov4);
    end
  endtask

  // rst_n low, clock idle: combinational path must still work.
  task test_truth_table;
    logic [1:0] ab;
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a1 = ab[1]; b1 = ab[0];
      #10;
      n_tests++;
      if (y1 !== ((i == 3) ? 1'b1 : 1'b0) || ao1 !== ((i == 3) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL truth_%0d%0d got Y=%b all_ones=%b want %0d", ab[1], ab[0], y1, ao1, (i == 3));
      end
    end
    a1 = 0; b1 = 0;
  endtask

  task test_vector_and;
    a8 = 8'hF0; b8 = 8'h3C; #1;
    n_tests++;
    if (y8 !== 8'h30 || ao8 !== 1'b0) begin
      n_fail++; $display("FAIL vec_f0_3c got Y=%h all_ones=%b want 30 0", y8, ao8);
    end
    a8 = 8'hFF; b8 = 8'hFF; #1;
    n_tests++;
    if (y8 !== 8'hFF || ao8 !== 1'b1) begin
      n_fail++; $display("FAIL vec_ff_ff got Y=%h all_ones=%b want ff 1", y8, ao8);
    end
    a8 = 8'hFE; #1;
    n_tests++;
    if (y8 !== 8'hFE || ao8 !== 1'b0) begin
      n_fail++; $display("FAIL vec_fe_ff got Y=%h all_ones=%b want fe 0", y8, ao8);
    end
    a8 = 0; b8 = 0;
  endtask

  // One-cycle valid on WIDTH=1, PIPE_STAGES=2: visible only after edge 2.
  task test_latency;
    @(negedge clk);
    a1 = 1; b1 = 1; v1 = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      a1 = 0; b1 = 0; v1 = 0;
      n_tests++;
      if (yq1 !== ((k == 2) ? 1'b1 : 1'b0) || ov1 !== ((k == 2) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL latency2_edge%0d got yq=%b ov=%b want %0d", k, yq1, ov1, (k == 2));
      end
    end
  endtask

  task test_latency_p4;
    logic [3:0] exp_y;
    @(negedge clk);
    a4 = 4'hB; b4 = 4'hE; v4 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      a4 = 0; b4 = 0; v4 = 0;
      exp_y = (k == 4) ? 4'hA : 4'h0;
      n_tests++;
      if (yq4 !== exp_y || ov4 !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL latency4_edge%0d got yq=%h ov=%b want %h %0d", k, yq4, ov4, exp_y, (k == 4));
      end
    end
  endtask

  // Data stages capture even when in_valid is low.
  task test_invalid_data;
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C; v8 = 0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (yq8 !== 8'h30 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL invalid_track got yq=%h ov=%b want 30 0", yq8, ov8);
    end
    a8 = 0; b8 = 0;
  endtask

  task test_async_reset;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; v8 = 1;
    @(negedge clk);
    a8 = 0; b8 = 0; v8 = 0;
    @(negedge clk);
    n_tests++;
    if (yq8 !== 8'hFF || ov8 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got yq=%h ov=%b want ff 1", yq8, ov8);
    end
    // Mid-cycle, well away from any edge.
    #1 rst_n = 0; a8 = 8'h0F; b8 = 8'h3C;
    #1;
    n_tests++;
    if (yq8 !== 8'h00 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL async_clear got yq=%h ov=%b want 00 0", yq8, ov8);
    end
    n_tests++;
    if (y8 !== 8'h0C || ao8 !== 1'b0) begin
      n_fail++; $display("FAIL y_in_reset got Y=%h all_ones=%b want 0c 0", y8, ao8);
    end
    a8 = 8'h5A; b8 = 8'hFF; v8 = 1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (yq8 !== 8'h00 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL held_in_reset got yq=%h ov=%b want 00 0", yq8, ov8);
    end
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (yq8 !== 8'h00 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_edge1 got yq=%h ov=%b want 00 0", yq8, ov8);
    end
    @(negedge clk);
    n_tests++;
    if (yq8 !== 8'h5A || ov8 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_edge2 got yq=%h ov=%b want 5a 1", yq8, ov8);
    end
    a8 = 0; b8 = 0; v8 = 0;
  endtask

`ifdef AND_GATE_STATS_EN
  task test_stats;
    @(negedge clk);
    rst_n = 0;
    #1;
    n_tests++;
    if (hc1 !== 16'h0000) begin
      n_fail++; $display("FAIL stats_reset got %h want 0000", hc1);
    end
    #1 rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a1 = 1;
      b1 = (k >= 5 && k < 8) ? 1'b0 : 1'b1;
      v1 = (k < 8) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    a1 = 0; b1 = 0; v1 = 0;
    @(negedge clk);
    n_tests++;
    if (hc1 !== 16'd5) begin
      n_fail++; $display("FAIL stats_count got %0d want 5", hc1);
    end
    a1 = 1; b1 = 1; v1 = 1;
    for (int k = 0; k < 65529; k++) @(negedge clk);
    a1 = 0; b1 = 0; v1 = 0;
    @(negedge clk);
    n_tests++;
    if (hc1 !== 16'hFFFE) begin
      n_fail++; $display("FAIL stats_fffe got %h want fffe", hc1);
    end
    a1 = 1; b1 = 1; v1 = 1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    a1 = 0; b1 = 0; v1 = 0;
    @(negedge clk);
    n_tests++;
    if (hc1 !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_saturate got %h want ffff", hc1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_vector_and();
    clk_en = 1;
    @(negedge clk);
    rst_n = 1;
    test_latency();
    test_latency_p4();
    test_invalid_data();
    test_async_reset();
`ifdef AND_GATE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Bitwise 2-input AND with a combinational output Y, plus a registered, valid-qualified copy for timing-closed consumers.
- Used as a basic logic primitive and as a teaching/lab reference block in the e-Lab design.
- Y must follow A & B with no clock dependence, so the block works unclocked.

Parameters:
- WIDTH, 1, bit width of A, B, Y and y_q.
- PIPE_STAGES, 1, register stages on the registered path (1..4); 0 is illegal and must raise an elaboration error.

Ports:
- clk  input  1  rising-edge clock for the registered path only.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path.
- Y  output  WIDTH  combinational A & B.
- y_q  output  WIDTH  A & B delayed PIPE_STAGES cycles.
- out_valid  output  1  in_valid delayed PIPE_STAGES cycles.
- all_ones  output  1  combinational reduction-AND of Y (1 when every bit of A & B is 1).

Behaviour:
- Y = A & B bitwise, purely combinational, independent of clk and rst_n.
  - Y is also correct while rst_n = 0 and with clk static.
  - Truth table per bit: 00→0, 01→0, 10→0, 11→1.
- all_ones = &Y, combinational.
- Registered path is a PIPE_STAGES-deep shift of {A & B, in_valid}, sampled on the rising clk edge.
  - Latency is exactly PIPE_STAGES cycles.
  - No backpressure; out_valid is informational only.
- Data stages capture unconditionally (no enable gating), so y_q tracks A & B even when in_valid = 0.
- Reset:
  - rst_n low asynchronously clears all stages: y_q = 0, out_valid = 0.
  - Reset asserted mid-stream discards in-flight data.
  - On deassertion, the first capture happens at the next rising edge.
- X/Z on an input: Y bit follows Verilog & semantics (0 & X = 0, 1 & X = X). No special handling.

Optional Feature:
- Macro: AND_GATE_STATS_EN.
- When defined, add output hit_cnt (16 bits).
  - Counts rising edges where in_valid = 1 and all_ones = 1.
  - Saturates at 16'hFFFF.
  - Cleared asynchronously by rst_n.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package and_gate_pkg:
  - PIPE_STAGES_MAX = 4.
  - STATS_CNT_W = 16.
  - Legality check function for PIPE_STAGES.
- One sub-module and_gate_reg_stage: single WIDTH+1-bit flop with async active-low clear, instantiated PIPE_STAGES times via generate.
- The combinational AND and the reduction live in the top module.

Test Plan:
- Unclocked truth table (WIDTH=1, rst_n=0, clk idle): apply A,B = 00, 01, 10, 11, each held 10 ns.
  - Required Y = 0, 0, 0, 1.
  - Required all_ones = 0, 0, 0, 1.
- Vector AND (WIDTH=8): A=8'hF0, B=8'h3C → Y=8'h30, all_ones=0. A=B=8'hFF → Y=8'hFF, all_ones=1.
- Latency (PIPE_STAGES=2): rst_n=1; drive A=1, B=1, in_valid=1 for one cycle, then 0s.
  - Required: y_q=1 and out_valid=1 exactly 2 edges later for one cycle, 0 otherwise.
- Async reset mid-flight: pull rst_n low between edges while a valid is in the pipe.
  - Required: y_q=0 and out_valid=0 immediately, with no clock edge.
  - Y still equals A & B.
- Stats (AND_GATE_STATS_EN): 5 valid cycles with A=B=1 plus 3 cycles with B=0 → hit_cnt=5.
  - Force the counter to 16'hFFFE, then apply 3 hits → holds 16'hFFFF.
